branch_predictor: RTL and testbench

//  Parametrised dynamic conditional-branch predictor. Fetch stage indexes a table of saturating counters
//  to guess taken/not-taken for BEQ..BGEU (conditionalPCSrc). Execute stage resolves the branch, trains
//  the counter, flags mispredicts and keeps a mispredict count.

---
 rtl/branch_predictor.sv | 163 ++++++++++++++++
 tb/tb_branch_predictor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: dynamic conditional-branch predictor built from a table of
// saturating counters. Fetch reads the table to guess taken/not-taken, execute
// trains the addressed counter, flags mispredicts and keeps a saturating total.
// Optional feature macro: GSHARE_EN. When defined, a global history register
// is XORed into the fetch index (gshare). When undefined, the index is the
// word-aligned PC bits alone (bimodal) and no history flops exist.
//
// Handshake: there is no back-pressure. An update is consumed on the clock
// edge of any cycle in RUN where updateValid_E=1 and updateCond_E!=NO_BRANCH;
// all other cycles leave table, history and statistics untouched.
module branch_predictor #(
    parameter int BIT_COUNT    = 32,
    parameter int ENTRIES      = 64,
    parameter int COUNTER_BITS = 2,
    parameter int STAT_BITS    = 32,
    parameter int IDX_BITS     = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_COUNT-1:0] predictPC_F,
    output logic [IDX_BITS-1:0]  predictIndex_F,
    output logic                 predictTaken_F,
    output logic                 ready,
    input  logic                 updateValid_E,
    input  logic [2:0]           updateCond_E,
    input  logic [IDX_BITS-1:0]  updateIndex_E,
    input  logic                 predictedTaken_E,
    input  logic                 actualTaken_E,
    output logic                 mispredict_E,
    output logic [STAT_BITS-1:0] mispredictCount,
    output logic                 o_dbg_state
);

    localparam logic [2:0] NO_BRANCH = 3'd0;
    localparam logic [COUNTER_BITS-1:0] INIT_VAL =
        COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);
    localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;
    localparam logic [IDX_BITS-1:0]     LAST_IDX = IDX_BITS'(ENTRIES - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [IDX_BITS-1:0]      r_ptr;
    logic [COUNTER_BITS-1:0]  r_table [ENTRIES];
    logic [STAT_BITS-1:0]     r_count;

    logic                     w_run;
    logic                     w_train;
    logic                     w_mispredict;
    logic [IDX_BITS-1:0]      w_base;
    logic [IDX_BITS-1:0]      w_index;
    logic [COUNTER_BITS-1:0]  w_ctr_cur;
    logic [COUNTER_BITS-1:0]  w_ctr_next;
    logic                     w_unused_pc;

    // Only the word-aligned index bits of the PC participate in prediction.
    assign w_base      = predictPC_F[IDX_BITS+1:2];
    assign w_unused_pc = ^{predictPC_F[BIT_COUNT-1:IDX_BITS+2], predictPC_F[1:0]};

`ifdef GSHARE_EN
    logic [IDX_BITS-1:0] r_ghr;

    // Global history shifts in each trained outcome; cleared with the table.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ghr <= '0;
        end else if (w_train) begin
            r_ghr <= (r_ghr << 1) | IDX_BITS'(actualTaken_E);
        end
    end

    assign w_index = w_base ^ r_ghr;
`else
    assign w_index = w_base;
`endif

    // FSM state register; any low reset cycle forces a fresh table walk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and the qualified strobes derived from the current state.
    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        w_train      = 1'b0;
        w_mispredict = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_ptr == LAST_IDX) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_run        = 1'b1;
                w_train      = updateValid_E && (updateCond_E != NO_BRANCH);
                w_mispredict = w_train && (predictedTaken_E != actualTaken_E);
            end
            default: w_state_next = S_INIT;
        endcase
    end

    // Saturating step of the counter addressed by the execute-stage index.
    always_comb begin
        w_ctr_cur  = r_table[updateIndex_E];
        w_ctr_next = w_ctr_cur;
        if (actualTaken_E) begin
            if (w_ctr_cur != CTR_MAX) begin
                w_ctr_next = w_ctr_cur + 1'b1;
            end
        end else begin
            if (w_ctr_cur != '0) begin
                w_ctr_next = w_ctr_cur - 1'b1;
            end
        end
    end

    // Initialisation pointer walks every entry once per INIT phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (r_state == S_INIT) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Table writes: INIT fill, then training. No read bypass, so a fetch of the
    // entry being trained sees the pre-update value this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (r_state == S_INIT) begin
                r_table[r_ptr] <= INIT_VAL;
            end else if (w_train) begin
                r_table[updateIndex_E] <= w_ctr_next;
            end
        end
    end

    // Mispredict total, holding once it reaches all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_mispredict && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign predictIndex_F  = w_index;
    assign predictTaken_F  = w_run && r_table[w_index][COUNTER_BITS-1];
    assign ready           = w_run;
    assign mispredict_E    = w_mispredict;
    assign mispredictCount = r_count;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: randomized and directed stimulus for branch_predictor,
// checked against a behavioural model holding counter values as integers.
// Follows GSHARE_EN the same way as the design build.
module tb_branch_predictor;

    localparam int BIT_COUNT    = 32;
    localparam int ENTRIES      = 64;
    localparam int COUNTER_BITS = 2;
    localparam int STAT_BITS    = 32;
    localparam int IDX_BITS     = 6;
    localparam int CTR_MAX      = (1 << COUNTER_BITS) - 1;
    localparam int INIT_VAL     = (1 << (COUNTER_BITS - 1)) - 1;
    localparam int TAKEN_TH     = 1 << (COUNTER_BITS - 1);
`ifdef GSHARE_EN
    localparam int T6_INDEX     = 3;
`else
    localparam int T6_INDEX     = 5;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [BIT_COUNT-1:0] predictPC_F = '0;
    logic [IDX_BITS-1:0]  predictIndex_F;
    logic                 predictTaken_F;
    logic                 ready;
    logic                 updateValid_E = 1'b0;
    logic [2:0]           updateCond_E = 3'd0;
    logic [IDX_BITS-1:0]  updateIndex_E = '0;
    logic                 predictedTaken_E = 1'b0;
    logic                 actualTaken_E = 1'b0;
    logic                 mispredict_E;
    logic [STAT_BITS-1:0] mispredictCount;
    logic                 o_dbg_state;

    // Reference model state.
    int     ctr_model [ENTRIES];
    int     ghr_model;
    longint count_model;
    bit     ready_model;

    int n_checks = 0;
    int n_errors = 0;

    branch_predictor #(
        .BIT_COUNT   (BIT_COUNT),
        .ENTRIES     (ENTRIES),
        .COUNTER_BITS(COUNTER_BITS),
        .STAT_BITS   (STAT_BITS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .predictPC_F     (predictPC_F),
        .predictIndex_F  (predictIndex_F),
        .predictTaken_F  (predictTaken_F),
        .ready           (ready),
        .updateValid_E   (updateValid_E),
        .updateCond_E    (updateCond_E),
        .updateIndex_E   (updateIndex_E),
        .predictedTaken_E(predictedTaken_E),
        .actualTaken_E   (actualTaken_E),
        .mispredict_E    (mispredict_E),
        .mispredictCount (mispredictCount),
        .o_dbg_state     (o_dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_index(input logic [BIT_COUNT-1:0] pc);
        return (int'(pc >> 2) ^ ghr_model) & (ENTRIES - 1);
    endfunction

    function automatic logic [BIT_COUNT-1:0] pc_for(input int idx);
        return BIT_COUNT'((idx ^ ghr_model) << 2);
    endfunction

    function automatic bit model_pred(input int idx);
        return ready_model && (ctr_model[idx] >= TAKEN_TH);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) ctr_model[i] = INIT_VAL;
        ghr_model   = 0;
        count_model = 0;
        ready_model = 1'b0;
    endfunction

    // Drive a fetch PC and compare index and prediction with the model.
    task automatic check_pred(input logic [BIT_COUNT-1:0] pc);
        int idx;
        predictPC_F = pc;
        #1;
        idx = model_index(pc);
        check("pred_index", predictIndex_F, idx);
        check("pred_taken", predictTaken_F, model_pred(idx));
    endtask

    // Present one execute-stage update for a cycle and advance the model.
    task automatic apply(input bit valid, input int cond, input int idx, input bit pred, input bit act);
        bit exp_mis;
        bit trained;
        updateValid_E    = valid;
        updateCond_E     = cond[2:0];
        updateIndex_E    = idx[IDX_BITS-1:0];
        predictedTaken_E = pred;
        actualTaken_E    = act;
        #1;
        trained = ready_model && valid && (cond != 0);
        exp_mis = trained && (pred != act);
        check("mispredict", mispredict_E, exp_mis);
        @(posedge clk);
        if (trained) begin
            if (act) ctr_model[idx] = (ctr_model[idx] < CTR_MAX) ? ctr_model[idx] + 1 : CTR_MAX;
            else     ctr_model[idx] = (ctr_model[idx] > 0) ? ctr_model[idx] - 1 : 0;
`ifdef GSHARE_EN
            ghr_model = ((ghr_model << 1) | int'(act)) & (ENTRIES - 1);
`endif
        end
        if (exp_mis && count_model < ((64'd1 << STAT_BITS) - 1)) count_model++;
        #1;
        updateValid_E = 1'b0;
        check("mis_count", mispredictCount, count_model);
    endtask

    // Walk through INIT while hammering the update port, which must be ignored.
    task automatic wait_init();
        for (int i = 0; i < ENTRIES; i++) begin
            check("init_ready", ready, 1'b0);
            apply(1'b1, $urandom_range(1, 7), $urandom_range(0, ENTRIES - 1), 1'b0, 1'b1);
        end
        ready_model = 1'b1;
        check("ready_after_init", ready, 1'b1);
    endtask

    // Hold reset low for a number of cycles, check the quiet outputs, then init.
    task automatic do_reset(input int cycles);
        reset = 1'b0;
        updateValid_E    = 1'b1;
        updateCond_E     = 3'd1;
        predictedTaken_E = 1'b0;
        actualTaken_E    = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        model_reset();
        check("rst_ready", ready, 1'b0);
        check("rst_count", mispredictCount, 0);
        check("rst_pred", predictTaken_F, 1'b0);
        check("rst_mispredict", mispredict_E, 1'b0);
        updateValid_E = 1'b0;
        reset = 1'b1;
        wait_init();
    endtask

    initial begin
        int idx;
        longint cnt_before;
        bit pred;

        model_reset();

        // 1: reset, INIT length, all predictions not-taken afterwards.
        do_reset(2);
        for (int pc = 0; pc <= 'hFC; pc += 4) check_pred(BIT_COUNT'(pc));

        // 2: entry 5 taken twice, then not-taken three times.
        for (int k = 0; k < 2; k++) apply(1'b1, 1, 5, model_pred(5), 1'b1);
        check_pred(pc_for(5));
        check("t2_taken", predictTaken_F, 1'b1);
        for (int k = 0; k < 3; k++) apply(1'b1, 1, 5, model_pred(5), 1'b0);
        check_pred(pc_for(5));
        check("t2_not_taken", predictTaken_F, 1'b0);

        // 3: entry 3 saturates high, one not-taken still predicts taken.
        for (int k = 0; k < 4; k++) apply(1'b1, 2, 3, model_pred(3), 1'b1);
        apply(1'b1, 2, 3, model_pred(3), 1'b0);
        check_pred(pc_for(3));
        check("t3_still_taken", predictTaken_F, 1'b1);

        // 4: mispredict on BLT counts; NO_BRANCH neither flags nor trains.
        cnt_before = count_model;
        apply(1'b1, 4, 7, 1'b0, 1'b1);
        check("t4_count_inc", mispredictCount, cnt_before + 1);
        apply(1'b1, 0, 7, 1'b0, 1'b1);
        check("t4_count_hold", mispredictCount, cnt_before + 1);
        check_pred(pc_for(7));

        // Randomized mix of fetches and updates, including same-index collisions.
        for (int n = 0; n < 400; n++) begin
            idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ENTRIES - 1) : $urandom_range(0, 7);
            pred = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : model_pred(idx);
            predictPC_F = ($urandom_range(0, 1) == 1) ? pc_for(idx) : $urandom;
            #1;
            check("rnd_pred_taken", predictTaken_F, model_pred(model_index(predictPC_F)));
            apply($urandom_range(0, 4) != 0, $urandom_range(0, 7), idx, pred, 1'($urandom_range(0, 1)));
        end

        // 5: train entry 5 high, single-cycle reset mid-RUN discards it all.
        for (int k = 0; k < 3; k++) apply(1'b1, 1, 5, model_pred(5), 1'b1);
        check_pred(pc_for(5));
        check("t5_trained", predictTaken_F, 1'b1);
        do_reset(1);
        check_pred(pc_for(5));
        check("t5_untrained", predictTaken_F, 1'b0);
        check("t5_count_zero", mispredictCount, 0);

        // 6: history taken,taken,not-taken then fetch PC 0x14 and train entry 3.
        apply(1'b1, 1, 10, model_pred(10), 1'b1);
        apply(1'b1, 1, 10, model_pred(10), 1'b1);
        apply(1'b1, 1, 10, model_pred(10), 1'b0);
        predictPC_F = 'h14;
        #1;
        check("t6_index", predictIndex_F, T6_INDEX);
        apply(1'b1, 1, 3, model_pred(3), 1'b1);
        for (int pc = 0; pc <= 'hFC; pc += 4) check_pred(BIT_COUNT'(pc));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
